// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl
// Per-access miss controller for an 8-way set-associative data cache.
// Picks the way for each lookup (hit way, lowest invalid way, or the pLRU
// victim). On a miss it writes back a dirty victim and refills the line, then
// commits the fill and issues one pLRU update. Outputs are decoded from the
// state register and the fields captured at accept time only.
module cache_miss_ctrl #(
    parameter int unsigned INDEX     = 5,
    parameter int unsigned INDEX_WAY = 3,
    parameter int unsigned TAG_W     = 22,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    // Lookup from tag compare
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [INDEX-1:0]       req_index_i,
    input  logic [TAG_W-1:0]       req_tag_i,
    input  logic                   req_hit_i,
    input  logic [INDEX_WAY-1:0]   req_hit_way_i,
    input  logic [7:0]             set_valid_i,
    input  logic [7:0]             set_dirty_i,
    input  logic [8*TAG_W-1:0]     set_tags_i,

    // pLRU replacement tree
    input  logic [INDEX_WAY-1:0]   plru_way_i,
    output logic                   plru_valid_o,
    output logic [INDEX-1:0]       plru_index_o,
    output logic [INDEX_WAY-1:0]   plru_way_o,

    // Memory side
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [TAG_W+INDEX-1:0] mem_addr_o,
    input  logic                   mem_ack_i,

    // Tag/data array fill
    output logic                   fill_we_o,
    output logic [INDEX-1:0]       fill_index_o,
    output logic [INDEX_WAY-1:0]   fill_way_o,
    output logic [TAG_W-1:0]       fill_tag_o,

    // Completion and statistics
    output logic                   done_o,
    output logic [INDEX_WAY-1:0]   done_way_o,
    output logic [CNT_W-1:0]       miss_cnt_o
);

    localparam int unsigned WAYS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StRefill,
        StCommit
    } state_e;

    state_e state_q, state_d;

    // Fields captured when a lookup is accepted
    logic [INDEX-1:0]     index_q;
    logic [TAG_W-1:0]     tag_q;
    logic                 hit_q;
    logic [INDEX_WAY-1:0] way_q;
    logic                 vic_valid_q;
    logic                 vic_dirty_q;
    logic [TAG_W-1:0]     vic_tag_q;
    logic [CNT_W-1:0]     miss_cnt_q;

    // Way selection for the incoming lookup
    logic [INDEX_WAY-1:0] pick_way;
    logic                 pick_valid;
    logic                 pick_dirty;
    logic [TAG_W-1:0]     pick_tag;
    logic                 accept;

    assign accept = (state_q == StIdle) && req_valid_i;

    // Choose hit way, else lowest invalid way, else pLRU victim; look up its state
    always_comb begin
        pick_way = plru_way_i;
        // Scanning downward leaves the lowest invalid way as the final winner
        for (int n = WAYS - 1; n >= 0; n--) begin
            if (!set_valid_i[n]) begin
                pick_way = INDEX_WAY'(n);
            end
        end
        if (req_hit_i) begin
            pick_way = req_hit_way_i;
        end
        pick_valid = set_valid_i[pick_way];
        pick_dirty = set_dirty_i[pick_way];
        pick_tag   = '0;
        for (int n = 0; n < WAYS; n++) begin
            if (pick_way == INDEX_WAY'(n)) begin
                pick_tag = set_tags_i[n*TAG_W +: TAG_W];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the lookup and its chosen way on accept; hold while busy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            index_q     <= '0;
            tag_q       <= '0;
            hit_q       <= 1'b0;
            way_q       <= '0;
            vic_valid_q <= 1'b0;
            vic_dirty_q <= 1'b0;
            vic_tag_q   <= '0;
        end else if (accept) begin
            index_q     <= req_index_i;
            tag_q       <= req_tag_i;
            hit_q       <= req_hit_i;
            way_q       <= pick_way;
            vic_valid_q <= pick_valid;
            vic_dirty_q <= pick_dirty;
            vic_tag_q   <= pick_tag;
        end
    end

    // Saturating miss counter, bumped once per committed miss
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt_q <= '0;
        end else if (state_q == StCommit && !hit_q && miss_cnt_q != {CNT_W{1'b1}}) begin
            miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    if (req_hit_i) begin
                        state_d = StCommit;
                    end else if (pick_valid && pick_dirty) begin
                        state_d = StWriteback;
                    end else begin
                        state_d = StRefill;
                    end
                end
            end
            StWriteback: begin
                if (mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                if (mem_ack_i) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output decode from state and captured fields; idle values are all zero
    always_comb begin
        req_ready_o  = 1'b0;
        plru_valid_o = 1'b0;
        plru_index_o = '0;
        plru_way_o   = '0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_addr_o   = '0;
        fill_we_o    = 1'b0;
        fill_index_o = '0;
        fill_way_o   = '0;
        fill_tag_o   = '0;
        done_o       = 1'b0;
        done_way_o   = '0;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
            end
            StWriteback: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                mem_addr_o = {vic_tag_q, index_q};
            end
            StRefill: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {tag_q, index_q};
            end
            StCommit: begin
                plru_valid_o = 1'b1;
                plru_index_o = index_q;
                plru_way_o   = way_q;
                done_o       = 1'b1;
                done_way_o   = way_q;
                if (!hit_q) begin
                    fill_we_o    = 1'b1;
                    fill_index_o = index_q;
                    fill_way_o   = way_q;
                    fill_tag_o   = tag_q;
                end
            end
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    assign miss_cnt_o = miss_cnt_q;

    // Victim valid is captured for visibility into the access; dirty alone
    // does not trigger write-back without it, which the next-state logic uses
    // directly from the lookup.
    logic unused_vic_valid;
    assign unused_vic_valid = vic_valid_q ^ vic_dirty_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Self-checking bench for cache_miss_ctrl: directed scenarios plus randomized
// accesses checked against a behavioural model of way choice and sequencing.
module tb_cache_miss_ctrl;

    localparam int unsigned INDEX     = 5;
    localparam int unsigned INDEX_WAY = 3;
    localparam int unsigned TAG_W     = 22;
    localparam int unsigned CNT_W     = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_ni;
    logic                   req_valid_i;
    logic [INDEX-1:0]       req_index_i;
    logic [TAG_W-1:0]       req_tag_i;
    logic                   req_hit_i;
    logic [INDEX_WAY-1:0]   req_hit_way_i;
    logic [7:0]             set_valid_i;
    logic [7:0]             set_dirty_i;
    logic [8*TAG_W-1:0]     set_tags_i;
    logic [INDEX_WAY-1:0]   plru_way_i;
    logic                   mem_ack_i;

    logic                   req_ready_o;
    logic                   plru_valid_o;
    logic [INDEX-1:0]       plru_index_o;
    logic [INDEX_WAY-1:0]   plru_way_o;
    logic                   mem_req_o;
    logic                   mem_we_o;
    logic [TAG_W+INDEX-1:0] mem_addr_o;
    logic                   fill_we_o;
    logic [INDEX-1:0]       fill_index_o;
    logic [INDEX_WAY-1:0]   fill_way_o;
    logic [TAG_W-1:0]       fill_tag_o;
    logic                   done_o;
    logic [INDEX_WAY-1:0]   done_way_o;
    logic [CNT_W-1:0]       miss_cnt_o;

    // Second instance with a 2-bit counter sharing the same stimulus
    logic                   s_req_ready;
    logic                   s_plru_valid;
    logic [INDEX-1:0]       s_plru_index;
    logic [INDEX_WAY-1:0]   s_plru_way;
    logic                   s_mem_req;
    logic                   s_mem_we;
    logic [TAG_W+INDEX-1:0] s_mem_addr;
    logic                   s_fill_we;
    logic [INDEX-1:0]       s_fill_index;
    logic [INDEX_WAY-1:0]   s_fill_way;
    logic [TAG_W-1:0]       s_fill_tag;
    logic                   s_done;
    logic [INDEX_WAY-1:0]   s_done_way;
    logic [1:0]             s_miss_cnt;

    cache_miss_ctrl #(
        .INDEX(INDEX), .INDEX_WAY(INDEX_WAY), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_index_i(req_index_i), .req_tag_i(req_tag_i),
        .req_hit_i(req_hit_i), .req_hit_way_i(req_hit_way_i),
        .set_valid_i(set_valid_i), .set_dirty_i(set_dirty_i), .set_tags_i(set_tags_i),
        .plru_way_i(plru_way_i), .plru_valid_o(plru_valid_o),
        .plru_index_o(plru_index_o), .plru_way_o(plru_way_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i),
        .fill_we_o(fill_we_o), .fill_index_o(fill_index_o),
        .fill_way_o(fill_way_o), .fill_tag_o(fill_tag_o),
        .done_o(done_o), .done_way_o(done_way_o), .miss_cnt_o(miss_cnt_o)
    );

    cache_miss_ctrl #(
        .INDEX(INDEX), .INDEX_WAY(INDEX_WAY), .TAG_W(TAG_W), .CNT_W(2)
    ) dut_small (
        .clk_i(clk), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(s_req_ready),
        .req_index_i(req_index_i), .req_tag_i(req_tag_i),
        .req_hit_i(req_hit_i), .req_hit_way_i(req_hit_way_i),
        .set_valid_i(set_valid_i), .set_dirty_i(set_dirty_i), .set_tags_i(set_tags_i),
        .plru_way_i(plru_way_i), .plru_valid_o(s_plru_valid),
        .plru_index_o(s_plru_index), .plru_way_o(s_plru_way),
        .mem_req_o(s_mem_req), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr),
        .mem_ack_i(mem_ack_i),
        .fill_we_o(s_fill_we), .fill_index_o(s_fill_index),
        .fill_way_o(s_fill_way), .fill_tag_o(s_fill_tag),
        .done_o(s_done), .done_way_o(s_done_way), .miss_cnt_o(s_miss_cnt)
    );

    int errors = 0;
    int checks = 0;
    int misses = 0;

    typedef struct {
        logic [INDEX-1:0]     idx;
        logic [TAG_W-1:0]     tag;
        logic                 hit;
        logic [2:0]           hway;
        logic [7:0]           valid;
        logic [7:0]           dirty;
        logic [8*TAG_W-1:0]   tags;
        logic [2:0]           plru;
    } req_t;

    typedef struct {
        int                   commit_cycle;
        bit                   timeout;
        bit                   ready_busy;
        bit                   addr_unstable;
        bit                   order_bad;
        int                   wb_n;
        int                   rf_n;
        logic [TAG_W+INDEX-1:0] wb_addr;
        logic [TAG_W+INDEX-1:0] rf_addr;
        logic                 plru_valid;
        logic [INDEX-1:0]     plru_index;
        logic [2:0]           plru_way;
        logic                 fill_we;
        logic [INDEX-1:0]     fill_index;
        logic [2:0]           fill_way;
        logic [TAG_W-1:0]     fill_tag;
        logic [2:0]           done_way;
        logic                 post_ready;
        logic                 post_done;
        logic                 post_plru;
        logic [CNT_W-1:0]     cnt;
        logic [1:0]           s_cnt;
    } obs_t;

    // Model: hit way, else lowest invalid way, else pLRU victim
    function automatic logic [2:0] model_way(input req_t r);
        if (r.hit) return r.hway;
        for (int n = 0; n < 8; n++) if (!r.valid[n]) return 3'(n);
        return r.plru;
    endfunction

    function automatic bit model_wb(input req_t r);
        logic [2:0] w;
        w = model_way(r);
        return !r.hit && r.valid[w] && r.dirty[w];
    endfunction

    function automatic logic [TAG_W-1:0] way_tag(input req_t r, input logic [2:0] w);
        return r.tags[int'(w)*TAG_W +: TAG_W];
    endfunction

    function automatic int sat3(input int m);
        return (m > 3) ? 3 : m;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.idx   = INDEX'($urandom);
        r.tag   = TAG_W'($urandom);
        r.hit   = ($urandom_range(0, 2) == 0);
        r.hway  = 3'($urandom);
        r.valid = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
        r.dirty = 8'($urandom);
        for (int n = 0; n < 8; n++) r.tags[n*TAG_W +: TAG_W] = TAG_W'($urandom);
        r.plru  = 3'($urandom);
        return r;
    endfunction

    // Drive one lookup, answer memory requests after the given latencies and
    // record what the controller did up to the cycle after completion.
    task automatic run_access(input req_t r, input int wb_lat, input int rf_lat,
                              input bit hold, output obs_t o);
        int k;
        bit fin;
        o = '{default: 0};
        @(negedge clk);
        req_index_i   = r.idx;
        req_tag_i     = r.tag;
        req_hit_i     = r.hit;
        req_hit_way_i = r.hway;
        set_valid_i   = r.valid;
        set_dirty_i   = r.dirty;
        set_tags_i    = r.tags;
        plru_way_i    = r.plru;
        req_valid_i   = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_valid_i = 1'b0;
        // Lookup fields change after accept; the controller must use its capture
        req_index_i   = ~r.idx;
        req_tag_i     = ~r.tag;
        req_hit_i     = ~r.hit;
        req_hit_way_i = ~r.hway;
        set_valid_i   = ~r.valid;
        set_dirty_i   = ~r.dirty;
        set_tags_i    = ~r.tags;
        plru_way_i    = ~r.plru;
        k   = 1;
        fin = 0;
        while (!fin && k <= 300) begin
            mem_ack_i = 1'b0;
            if (req_ready_o) o.ready_busy = 1;
            if (mem_req_o && mem_we_o) begin
                if (o.rf_n > 0) o.order_bad = 1;
                if (o.wb_n == 0) o.wb_addr = mem_addr_o;
                else if (mem_addr_o != o.wb_addr) o.addr_unstable = 1;
                o.wb_n++;
                if (o.wb_n == wb_lat) mem_ack_i = 1'b1;
            end else if (mem_req_o) begin
                if (o.rf_n == 0) o.rf_addr = mem_addr_o;
                else if (mem_addr_o != o.rf_addr) o.addr_unstable = 1;
                o.rf_n++;
                if (o.rf_n == rf_lat) mem_ack_i = 1'b1;
            end
            if (done_o) begin
                o.commit_cycle = k;
                o.plru_valid   = plru_valid_o;
                o.plru_index   = plru_index_o;
                o.plru_way     = plru_way_o;
                o.fill_we      = fill_we_o;
                o.fill_index   = fill_index_o;
                o.fill_way     = fill_way_o;
                o.fill_tag     = fill_tag_o;
                o.done_way     = done_way_o;
                fin = 1;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end
        if (!fin) o.timeout = 1;
        mem_ack_i = 1'b0;
        @(posedge clk);
        #1;
        o.post_ready = req_ready_o;
        o.post_done  = done_o;
        o.post_plru  = plru_valid_o;
        o.cnt        = miss_cnt_o;
        o.s_cnt      = s_miss_cnt;
        req_valid_i  = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni        = 1'b0;
        req_valid_i   = 1'b0;
        req_index_i   = '0;
        req_tag_i     = '0;
        req_hit_i     = 1'b0;
        req_hit_way_i = '0;
        set_valid_i   = '0;
        set_dirty_i   = '0;
        set_tags_i    = '0;
        plru_way_i    = '0;
        mem_ack_i     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
        end
        checks++;
        if ({plru_valid_o, mem_req_o, mem_we_o, fill_we_o, done_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b want 00000",
                     {plru_valid_o, mem_req_o, mem_we_o, fill_we_o, done_o});
        end
        checks++;
        if ({mem_addr_o, plru_index_o, plru_way_o, fill_index_o, fill_way_o, fill_tag_o,
             done_way_o} !== '0) begin
            errors++; $display("FAIL reset_fields: got nonzero address/way/tag want 0");
        end
        checks++;
        if (miss_cnt_o !== '0) begin
            errors++; $display("FAIL reset_cnt: got %0d want 0", miss_cnt_o);
        end
        misses = 0;
    endtask

    task automatic test_hit();
        req_t r;
        obs_t o;
        r = rand_req();
        r.idx = 5'd3; r.hit = 1'b1; r.hway = 3'd5;
        run_access(r, 1, 1, 0, o);
        checks++;
        if (o.commit_cycle !== 1 || o.timeout) begin
            errors++; $display("FAIL hit_latency: got %0d want 1", o.commit_cycle);
        end
        checks++;
        if ({o.plru_valid, o.plru_index, o.plru_way} !== {1'b1, 5'd3, 3'd5}) begin
            errors++;
            $display("FAIL hit_plru: got v=%b idx=%0d way=%0d want v=1 idx=3 way=5",
                     o.plru_valid, o.plru_index, o.plru_way);
        end
        checks++;
        if (o.fill_we !== 1'b0 || o.wb_n + o.rf_n != 0) begin
            errors++;
            $display("FAIL hit_no_fill: got fill_we=%b mem_cycles=%0d want 0/0",
                     o.fill_we, o.wb_n + o.rf_n);
        end
        checks++;
        if (o.cnt !== 16'd0 || o.post_ready !== 1'b1) begin
            errors++;
            $display("FAIL hit_after: got cnt=%0d ready=%b want 0/1", o.cnt, o.post_ready);
        end
    endtask

    task automatic test_invalid_way();
        req_t r;
        obs_t o;
        r = rand_req();
        r.idx = 5'd7; r.hit = 1'b0; r.valid = 8'b1110_1111; r.dirty = 8'hFF; r.plru = 3'd2;
        run_access(r, 1, 3, 0, o);
        misses++;
        checks++;
        if (o.wb_n != 0 || o.rf_addr !== {r.tag, 5'd7}) begin
            errors++;
            $display("FAIL inv_refill: got wb=%0d addr=%h want wb=0 addr=%h",
                     o.wb_n, o.rf_addr, {r.tag, 5'd7});
        end
        checks++;
        if ({o.fill_we, o.fill_way, o.fill_index, o.fill_tag} !== {1'b1, 3'd4, 5'd7, r.tag}) begin
            errors++;
            $display("FAIL inv_fill: got we=%b way=%0d idx=%0d tag=%h want 1/4/7/%h",
                     o.fill_we, o.fill_way, o.fill_index, o.fill_tag, r.tag);
        end
        checks++;
        if (o.commit_cycle != 4 || o.cnt !== 16'd1) begin
            errors++;
            $display("FAIL inv_timing_cnt: got commit=%0d cnt=%0d want 4/1",
                     o.commit_cycle, o.cnt);
        end
    endtask

    task automatic test_dirty_victim();
        req_t r;
        obs_t o;
        r = rand_req();
        r.hit = 1'b0; r.valid = 8'hFF; r.dirty = 8'b0100_0000; r.plru = 3'd6;
        r.tags[6*TAG_W +: TAG_W] = 22'h1ABCD;
        run_access(r, 2, 3, 0, o);
        misses++;
        checks++;
        if (o.wb_n != 2 || o.wb_addr !== {22'h1ABCD, r.idx}) begin
            errors++;
            $display("FAIL wb_addr: got n=%0d addr=%h want n=2 addr=%h",
                     o.wb_n, o.wb_addr, {22'h1ABCD, r.idx});
        end
        checks++;
        if (o.rf_n != 3 || o.rf_addr !== {r.tag, r.idx} || o.order_bad || o.addr_unstable) begin
            errors++;
            $display("FAIL wb_refill: got n=%0d addr=%h order_bad=%b want n=3 addr=%h",
                     o.rf_n, o.rf_addr, o.order_bad, {r.tag, r.idx});
        end
        checks++;
        if (o.done_way !== 3'd6 || o.commit_cycle != 6 || o.cnt !== 16'(misses)) begin
            errors++;
            $display("FAIL wb_commit: got way=%0d commit=%0d cnt=%0d want 6/6/%0d",
                     o.done_way, o.commit_cycle, o.cnt, misses);
        end
    endtask

    task automatic test_hold_valid();
        req_t r;
        obs_t o;
        r = rand_req();
        r.hit = 1'b0; r.valid = 8'hFF; r.dirty = 8'h00;
        run_access(r, 1, 10, 1, o);
        misses++;
        checks++;
        if (o.ready_busy || o.post_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_ready: got busy_ready=%b post_ready=%b want 0/1",
                     o.ready_busy, o.post_ready);
        end
        checks++;
        if (o.commit_cycle != 11 || o.fill_tag !== r.tag || o.rf_addr !== {r.tag, r.idx}) begin
            errors++;
            $display("FAIL hold_capture: got commit=%0d tag=%h want 11/%h",
                     o.commit_cycle, o.fill_tag, r.tag);
        end
        checks++;
        if (o.post_done !== 1'b0 || o.cnt !== 16'(misses)) begin
            errors++;
            $display("FAIL hold_once: got post_done=%b cnt=%0d want 0/%0d",
                     o.post_done, o.cnt, misses);
        end
    endtask

    task automatic test_reset_mid();
        req_t r;
        obs_t o;
        bit stray;
        r = rand_req();
        r.hit = 1'b0; r.valid = 8'hFF; r.dirty = 8'h00;
        @(negedge clk);
        req_index_i = r.idx; req_tag_i = r.tag; req_hit_i = 1'b0; req_hit_way_i = r.hway;
        set_valid_i = r.valid; set_dirty_i = r.dirty; set_tags_i = r.tags; plru_way_i = r.plru;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_refill: got req=%b we=%b want 1/0", mem_req_o, mem_we_o);
        end
        #1;
        rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, plru_valid_o, mem_req_o, mem_we_o, fill_we_o, done_o} !== 6'b100000
            || mem_addr_o !== '0 || miss_cnt_o !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: got rdy/strobes=%b addr=%h cnt=%0d want 100000/0/0",
                     {req_ready_o, plru_valid_o, mem_req_o, mem_we_o, fill_we_o, done_o},
                     mem_addr_o, miss_cnt_o);
        end
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        misses = 0;
        stray  = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (plru_valid_o || fill_we_o || done_o || mem_req_o) stray = 1;
        end
        checks++;
        if (stray) begin
            errors++; $display("FAIL rst_mid_stray: got strobe after reset want none");
        end
        r.hit = 1'b1; r.hway = 3'd2;
        run_access(r, 1, 1, 0, o);
        checks++;
        if (o.commit_cycle != 1 || o.done_way !== 3'd2 || o.cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_next: got commit=%0d way=%0d cnt=%0d want 1/2/0",
                     o.commit_cycle, o.done_way, o.cnt);
        end
    endtask

    task automatic test_saturate();
        req_t r;
        obs_t o;
        for (int i = 0; i < 5; i++) begin
            r = rand_req();
            r.hit = 1'b0; r.valid = 8'h00;
            run_access(r, 1, 1 + (i % 2), 0, o);
            misses++;
            checks++;
            if (o.s_cnt !== 2'(sat3(misses)) || o.cnt !== 16'(misses)) begin
                errors++;
                $display("FAIL sat_cnt[%0d]: got small=%0d wide=%0d want %0d/%0d",
                         i, o.s_cnt, o.cnt, sat3(misses), misses);
            end
        end
    endtask

    task automatic test_random();
        req_t r;
        obs_t o;
        logic [2:0] w;
        bit wb;
        int wl, rl, exp_commit;
        for (int i = 0; i < 40; i++) begin
            r  = rand_req();
            wl = $urandom_range(1, 4);
            rl = $urandom_range(1, 4);
            w  = model_way(r);
            wb = model_wb(r);
            exp_commit = r.hit ? 1 : ((wb ? wl : 0) + rl + 1);
            run_access(r, wl, rl, 0, o);
            if (!r.hit) misses++;
            checks++;
            if (o.timeout || o.commit_cycle != exp_commit || o.ready_busy) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: got commit=%0d busy_ready=%b want %0d/0",
                         i, o.commit_cycle, o.ready_busy, exp_commit);
            end
            checks++;
            if (o.done_way !== w || o.plru_way !== w || o.plru_index !== r.idx
                || o.plru_valid !== 1'b1) begin
                errors++;
                $display("FAIL rnd_way[%0d]: got done=%0d plru=%0d idx=%0d want %0d/%0d/%0d",
                         i, o.done_way, o.plru_way, o.plru_index, w, w, r.idx);
            end
            checks++;
            if ((wb ? {r.tags[int'(w)*TAG_W +: TAG_W], r.idx} : '0) !== o.wb_addr
                || o.wb_n != (wb ? wl : 0) || o.order_bad || o.addr_unstable) begin
                errors++;
                $display("FAIL rnd_wb[%0d]: got n=%0d addr=%h want n=%0d addr=%h",
                         i, o.wb_n, o.wb_addr, wb ? wl : 0,
                         wb ? {way_tag(r, w), r.idx} : '0);
            end
            checks++;
            if (o.rf_n != (r.hit ? 0 : rl)
                || (!r.hit && o.rf_addr !== {r.tag, r.idx})) begin
                errors++;
                $display("FAIL rnd_refill[%0d]: got n=%0d addr=%h want n=%0d addr=%h",
                         i, o.rf_n, o.rf_addr, r.hit ? 0 : rl, {r.tag, r.idx});
            end
            checks++;
            if (o.fill_we !== !r.hit
                || (!r.hit && {o.fill_index, o.fill_way, o.fill_tag} !== {r.idx, w, r.tag})) begin
                errors++;
                $display("FAIL rnd_fill[%0d]: got we=%b idx=%0d way=%0d tag=%h want %b/%0d/%0d/%h",
                         i, o.fill_we, o.fill_index, o.fill_way, o.fill_tag,
                         !r.hit, r.idx, w, r.tag);
            end
            checks++;
            if (o.cnt !== 16'(misses) || o.s_cnt !== 2'(sat3(misses))
                || o.post_ready !== 1'b1 || o.post_plru !== 1'b0) begin
                errors++;
                $display("FAIL rnd_after[%0d]: got cnt=%0d small=%0d ready=%b plru=%b want %0d/%0d/1/0",
                         i, o.cnt, o.s_cnt, o.post_ready, o.post_plru, misses, sat3(misses));
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_invalid_way();
        test_dirty_victim();
        test_hold_valid();
        test_reset_mid();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
